gpu_ram_loader: RTL and testbench

//  Bus-side initiator that bursts 32-bit words into or out of GPU local RAM (1K x 32) through the
//  RAM's ramen/gpu_memw/ram_addr strobe interface. Used to load GPU code/data before the GPU runs
//  and to read results back. Owns the RAM port only while bus_gnt is high (arbitrated vs. the GPU);

---
 rtl/gpu_ram_loader.sv | 196 +++++++++++++++++++
 tb/tb_gpu_ram_loader.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_ram_loader.sv
// Bus-side burst initiator between a host valid/ready stream pair and GPU local RAM.
// Owns the RAM strobe port only while the arbiter grant is high.
module gpu_ram_loader #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          i_sys_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic          i_dir_rd,
  input  logic [AW-1:0] i_base_addr,
  input  logic [AW:0]   i_length,
  input  logic          i_abort,
  output logic          o_bus_req,
  input  logic          i_bus_gnt,
  output logic [AW-1:0] o_ram_addr,
  output logic          o_ramen,
  output logic          o_gpu_memw,
  output logic [DW-1:0] o_ram_wdata,
  input  logic [DW-1:0] i_ram_rdata,
  input  logic          i_wr_valid,
  output logic          o_wr_ready,
  input  logic [DW-1:0] i_wr_data,
  output logic          o_rd_valid,
  input  logic          i_rd_ready,
  output logic [DW-1:0] o_rd_data,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_aborted
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARB   = 3'd1,
    S_WR    = 3'd2,
    S_RD    = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_addr;
  logic [AW:0]   r_count;
  logic          r_dir_rd;
  logic          r_aborted;
  logic          r_inflight;
  logic          r_head;
  logic [1:0]    r_occ;
  logic [DW-1:0] r_buf [2];

  logic          w_abort_take;
  logic          w_wr_fire;
  logic          w_rd_strobe;
  logic          w_pop;
  logic          w_push;
  logic          w_tail;
  logic          w_last;
  logic          w_active;
  logic [2:0]    w_room;

  // Handshake and strobe qualification; the read room term counts words
  // already buffered plus the one in flight, less any word leaving this cycle.
  always_comb begin
    w_active     = (r_state == S_ARB) || (r_state == S_WR) ||
                   (r_state == S_RD)  || (r_state == S_DRAIN);
    w_abort_take = i_abort && w_active;
    w_pop        = (r_occ != 2'd0) && i_rd_ready;
    w_push       = r_inflight;
    w_tail       = r_head ^ (r_occ == 2'd1);
    w_last       = (r_count == CNT_ONE);
    w_room       = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    w_wr_fire    = (r_state == S_WR) && i_bus_gnt && i_wr_valid && !i_abort;
    w_rd_strobe  = (r_state == S_RD) && i_bus_gnt && !i_abort && (w_room < 3'd2);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next = (i_length == '0) ? S_DONE : S_ARB;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_ARB: begin
        if (w_abort_take) begin
          w_next = S_DONE;
        end else if (i_bus_gnt) begin
          w_next = r_dir_rd ? S_RD : S_WR;
        end else begin
          w_next = S_ARB;
        end
      end
      S_WR: begin
        if (w_abort_take || (w_wr_fire && w_last)) begin
          w_next = S_DONE;
        end else begin
          w_next = S_WR;
        end
      end
      S_RD: begin
        if (w_abort_take) begin
          w_next = S_DONE;
        end else if (w_rd_strobe && w_last) begin
          w_next = S_DRAIN;
        end else begin
          w_next = S_RD;
        end
      end
      S_DRAIN: begin
        if (w_abort_take || (w_pop && (r_occ == 2'd1) && !r_inflight)) begin
          w_next = S_DONE;
        end else begin
          w_next = S_DRAIN;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_bus_req   = w_active;
    o_busy      = w_active;
    o_ramen     = w_wr_fire || w_rd_strobe;
    o_gpu_memw  = w_wr_fire;
    o_ram_wdata = w_wr_fire ? i_wr_data : '0;
    o_ram_addr  = r_addr;
    o_wr_ready  = (r_state == S_WR) && i_bus_gnt && !i_abort;
    o_rd_valid  = (r_occ != 2'd0);
    o_rd_data   = r_buf[r_head];
    o_done      = (r_state == S_DONE);
    o_aborted   = (r_state == S_DONE) && r_aborted;
  end

  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Transfer descriptor: loaded on start, stepped once per RAM strobe.
  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      r_addr    <= '0;
      r_count   <= '0;
      r_dir_rd  <= 1'b0;
      r_aborted <= 1'b0;
    end else if ((r_state == S_IDLE) && i_start) begin
      r_addr    <= i_base_addr;
      r_count   <= i_length;
      r_dir_rd  <= i_dir_rd;
      r_aborted <= 1'b0;
    end else if (w_abort_take) begin
      r_aborted <= 1'b1;
    end else if (w_wr_fire || w_rd_strobe) begin
      r_addr  <= r_addr + ADDR_ONE;
      r_count <= r_count - CNT_ONE;
    end else begin
      r_addr  <= r_addr;
      r_count <= r_count;
    end
  end

  // Two-entry read buffer; abort discards both buffered and in-flight words.
  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      r_inflight <= 1'b0;
      r_head     <= 1'b0;
      r_occ      <= 2'd0;
      r_buf[0]   <= '0;
      r_buf[1]   <= '0;
    end else if (w_abort_take) begin
      r_inflight <= 1'b0;
      r_head     <= 1'b0;
      r_occ      <= 2'd0;
    end else begin
      r_inflight <= w_rd_strobe;
      if (w_push) begin
        r_buf[w_tail] <= i_ram_rdata;
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
      r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: tb/tb_gpu_ram_loader.sv
// Scoreboard bench for gpu_ram_loader: directed transfers push expectations,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_gpu_ram_loader;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, dir_rd, abort, bus_gnt;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic [DW-1:0] ram_rdata, wr_data;
  logic          wr_valid, rd_ready;
  logic          bus_req, ramen, memw, wr_ready, rd_valid, busy, done, aborted;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, rd_data;

  always #5 clk = ~clk;

  gpu_ram_loader #(.AW(AW), .DW(DW)) dut (
    .i_sys_clk(clk), .i_reset(rst), .i_start(start), .i_dir_rd(dir_rd),
    .i_base_addr(base_addr), .i_length(length), .i_abort(abort),
    .o_bus_req(bus_req), .i_bus_gnt(bus_gnt), .o_ram_addr(ram_addr),
    .o_ramen(ramen), .o_gpu_memw(memw), .o_ram_wdata(ram_wdata),
    .i_ram_rdata(ram_rdata), .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
    .i_wr_data(wr_data), .o_rd_valid(rd_valid), .i_rd_ready(rd_ready),
    .o_rd_data(rd_data), .o_busy(busy), .o_done(done), .o_aborted(aborted)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [AW+DW-1:0] exp_wr[$];
  logic [DW-1:0]    exp_rd[$];
  logic             exp_done[$];
  logic [DW-1:0]    wq[$];
  logic [AW-1:0]    exp_rd_addr = '0;
  int               wr_strobes = 0;
  int               rd_strobes = 0;
  bit               bus_req_seen = 1'b0;
  int               rd_mode = 0;
  logic [DW-1:0]    mem [1024];

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %0h with nothing expected", name, act);
  endtask

  // RAM model: writes land and read data appears the cycle after a strobe.
  initial begin
    logic s_en, s_w;
    logic [AW-1:0] s_a;
    logic [DW-1:0] s_d;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 + i;
    ram_rdata = '0;
    forever begin
      @(negedge clk);
      s_en = ramen; s_w = memw; s_a = ram_addr; s_d = ram_wdata;
      @(posedge clk); #1;
      if (s_en && s_w) mem[s_a] = s_d;
      else if (s_en) ram_rdata = mem[s_a];
    end
  end

  initial begin
    rd_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rd_mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = ~rd_ready;
        default: rd_ready = 1'b0;
      endcase
    end
  end

  // Monitor / scoreboard
  initial begin
    logic [AW+DW-1:0] e;
    logic [DW-1:0] r;
    logic a;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus_req) bus_req_seen = 1'b1;
        if (ramen) check_eq("strobe_gnt", bus_gnt, 1);
        if (!ramen) check_eq("memw_idle", memw, 0);
        if (ramen && memw) begin
          wr_strobes++;
          if (exp_wr.size() == 0) fail_now("wr_unexpected", {ram_addr, ram_wdata});
          else begin
            e = exp_wr.pop_front();
            check_eq("wr_addr", ram_addr, e[AW+DW-1:DW]);
            check_eq("wr_data", ram_wdata, e[DW-1:0]);
          end
        end
        if (ramen && !memw) begin
          rd_strobes++;
          check_eq("rd_addr", ram_addr, exp_rd_addr);
          exp_rd_addr = exp_rd_addr + 10'd1;
        end
        if (rd_valid && rd_ready) begin
          if (exp_rd.size() == 0) fail_now("rd_unexpected", rd_data);
          else begin
            r = exp_rd.pop_front();
            check_eq("rd_data", rd_data, r);
          end
        end
        if (done) begin
          check_eq("busy_at_done", busy, 0);
          if (exp_done.size() == 0) fail_now("done_unexpected", aborted);
          else begin
            a = exp_done.pop_front();
            check_eq("aborted_flag", aborted, a);
          end
        end
      end
    end
  end

  task automatic do_start(input logic d, input logic [AW-1:0] b, input logic [AW:0] n);
    start = 1'b1; dir_rd = d; base_addr = b; length = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int cyc = 0;
    bit seen = 1'b0;
    while (!seen && cyc < 300) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      cyc++;
    end
    check_eq({name, "_done_seen"}, seen, 1);
    @(posedge clk); #1;
  endtask

  task automatic feed_writes(input int n, input int gap_after, input int gap_len);
    int sent = 0;
    int cyc = 0;
    int gap = 0;
    bit fire;
    wr_valid = 1'b1;
    wr_data = wq[0];
    while (sent < n && cyc < 300) begin
      @(negedge clk);
      fire = wr_valid && wr_ready;
      @(posedge clk); #1;
      cyc++;
      if (gap > 0) begin
        gap--;
        if (gap == 0) bus_gnt = 1'b1;
      end
      if (fire) begin
        void'(wq.pop_front());
        sent++;
        if (sent == gap_after) begin
          bus_gnt = 1'b0;
          gap = gap_len;
        end
      end
      wr_valid = (sent < n);
      if (wq.size() > 0) wr_data = wq[0];
    end
    wr_valid = 1'b0;
    check_eq("wr_feed_complete", sent, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; dir_rd = 1'b0; abort = 1'b0; bus_gnt = 1'b1;
    base_addr = '0; length = '0; wr_valid = 1'b0; wr_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_bus_req", bus_req, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_ramen", ramen, 0);
    check_eq("rst_rd_valid", rd_valid, 0);
    check_eq("rst_ram_addr", ram_addr, 0);
    check_eq("rst_wr_ready", wr_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // abort in IDLE is ignored
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check_eq("idle_abort_done", done, 0);
    @(posedge clk); #1;

    // write 4 words across the address wrap
    exp_wr.push_back({10'h3FE, 32'h11}); exp_wr.push_back({10'h3FF, 32'h22});
    exp_wr.push_back({10'h000, 32'h33}); exp_wr.push_back({10'h001, 32'h44});
    wq = '{32'h11, 32'h22, 32'h33, 32'h44};
    exp_done.push_back(1'b0);
    wr_strobes = 0;
    do_start(1'b0, 10'h3FE, 11'd4);
    feed_writes(4, 0, 0);
    wait_done("wr4");
    check_eq("wr4_strobes", wr_strobes, 4);
    check_eq("wr4_left", exp_wr.size(), 0);

    // read them back with rd_ready held high
    exp_rd = '{32'h11, 32'h22, 32'h33, 32'h44};
    exp_done.push_back(1'b0);
    exp_rd_addr = 10'h3FE; rd_strobes = 0;
    do_start(1'b1, 10'h3FE, 11'd4);
    wait_done("rd4");
    check_eq("rd4_strobes", rd_strobes, 4);
    check_eq("rd4_left", exp_rd.size(), 0);

    // read 8 with rd_ready toggling
    rd_mode = 1;
    repeat (2) @(posedge clk); #1;
    for (int i = 0; i < 8; i++) exp_rd.push_back(32'hA000_0010 + i);
    exp_done.push_back(1'b0);
    exp_rd_addr = 10'h010; rd_strobes = 0;
    do_start(1'b1, 10'h010, 11'd8);
    wait_done("rd8");
    check_eq("rd8_strobes", rd_strobes, 8);
    check_eq("rd8_left", exp_rd.size(), 0);
    rd_mode = 0;

    // write 6 with a 3-cycle grant gap after the second word
    for (int i = 0; i < 6; i++) begin
      exp_wr.push_back({10'h100 + 10'(i), 32'hB1 + 32'(i)});
      wq.push_back(32'hB1 + 32'(i));
    end
    exp_done.push_back(1'b0);
    wr_strobes = 0;
    do_start(1'b0, 10'h100, 11'd6);
    feed_writes(6, 2, 3);
    wait_done("wrgap");
    check_eq("wrgap_strobes", wr_strobes, 6);
    check_eq("wrgap_left", exp_wr.size(), 0);

    // zero-length start
    bus_req_seen = 1'b0;
    exp_done.push_back(1'b0);
    do_start(1'b0, 10'h055, 11'd0);
    @(negedge clk);
    check_eq("len0_done", done, 1);
    check_eq("len0_busy", busy, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("len0_bus_req_seen", bus_req_seen, 0);
    @(posedge clk); #1;

    // abort mid-read with the consumer stalled
    rd_mode = 2;
    repeat (2) @(posedge clk); #1;
    exp_done.push_back(1'b1);
    exp_rd_addr = 10'h200; rd_strobes = 0;
    do_start(1'b1, 10'h200, 11'd8);
    repeat (6) begin @(posedge clk); #1; end
    @(negedge clk);
    check_eq("abort_pre_rd_valid", rd_valid, 1);
    check_eq("abort_pre_strobes", rd_strobes, 2);
    @(posedge clk); #1;
    abort = 1'b1;
    @(negedge clk);
    check_eq("abort_cycle_ramen", ramen, 0);
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check_eq("abort_done", done, 1);
    check_eq("abort_aborted", aborted, 1);
    check_eq("abort_rd_valid", rd_valid, 0);
    @(posedge clk); #1;
    check_eq("abort_strobes", rd_strobes, 2);
    rd_mode = 0;
    repeat (2) @(posedge clk); #1;

    // reset in the middle of a write burst, then a clean transfer
    exp_wr.push_back({10'h300, 32'hC1});
    wr_valid = 1'b1; wr_data = 32'hC1;
    do_start(1'b0, 10'h300, 11'd6);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("rstmid_ramen_before", ramen, 1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("rstmid_ramen", ramen, 0);
    check_eq("rstmid_bus_req", bus_req, 0);
    check_eq("rstmid_busy", busy, 0);
    exp_wr.delete();
    exp_done.delete();
    wr_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    exp_wr.push_back({10'h300, 32'hD1}); exp_wr.push_back({10'h301, 32'hD2});
    wq = '{32'hD1, 32'hD2};
    exp_done.push_back(1'b0);
    wr_strobes = 0;
    do_start(1'b0, 10'h300, 11'd2);
    feed_writes(2, 0, 0);
    wait_done("post_rst");
    check_eq("post_rst_strobes", wr_strobes, 2);
    check_eq("post_rst_wr_left", exp_wr.size(), 0);
    check_eq("final_done_left", exp_done.size(), 0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
